// File: rtl/mux_rr_stream.sv
// N-channel valid/ready stream mux: static-select or round-robin grant feeding
// one registered output stage with full backpressure.
module mux_rr_stream #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    output logic [SELW-1:0] out_ch,
    input  logic            out_ready
);
    localparam logic [SELW:0] NUM = N[SELW:0];

    logic [N-1:0][W-1:0] ch_data;
    logic [SELW-1:0]     ptr;

    for (genvar k = 0; k < N; k++) begin : g_unpack
        assign ch_data[k] = in_data[k*W +: W];
    end

    // Round-robin: rotate the valid vector so bit 0 is channel ptr, then take
    // the lowest set bit and map the offset back to a channel index.
    logic [2*N-1:0]  vld_dbl;
    logic [N-1:0]    vld_rot;
    logic [SELW:0]   rr_off;
    logic [SELW:0]   rr_sum;
    logic [SELW-1:0] rr_g;
    logic            rr_hit;

    assign vld_dbl = {in_valid, in_valid};
    assign vld_rot = N'(vld_dbl >> ptr);

    always_comb begin
        rr_hit = 1'b0;
        rr_off = '0;
        for (int i = N-1; i >= 0; i--) begin
            if (vld_rot[i]) begin
                rr_hit = 1'b1;
                rr_off = i[SELW:0];
            end
        end
    end

    assign rr_sum = {1'b0, ptr} + rr_off;
    assign rr_g   = (rr_sum >= NUM) ? SELW'(rr_sum - NUM) : rr_sum[SELW-1:0];

    // Static select: out-of-range indices never grant.
    logic [N-1:0] st_vld;
    logic         st_hit;

    assign st_vld = in_valid >> sel;
    assign st_hit = ({1'b0, sel} < NUM) && st_vld[0];

    logic            hit;
    logic [SELW-1:0] g;
    logic            load_en;
    logic            xfer;

    assign hit     = mode ? rr_hit : st_hit;
    assign g       = mode ? rr_g : sel;
    assign load_en = !out_valid || out_ready;
    assign xfer    = hit && load_en && rst_n;

    assign in_ready = xfer ? (N'(1) << g) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (load_en) begin
            if (hit) begin
                out_valid <= 1'b1;
                out_data  <= ch_data[g];
                out_ch    <= g;
                if (mode) begin
                    ptr <= ({1'b0, g} == NUM - 1'b1) ? '0 : g + 1'b1;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mux_rr_stream.sv
// Bench for mux_rr_stream: directed vector table on N=4 and N=3 instances,
// then randomized traffic checked against a queue-free reference model.
module tb_mux_rr_stream;
    logic        clk;
    logic        rst_n;

    logic        a_mode, a_ordy, a_ov;
    logic [1:0]  a_sel, a_oc;
    logic [31:0] a_data;
    logic [3:0]  a_valid, a_rdy;
    logic [7:0]  a_od;

    logic        b_mode, b_ordy, b_ov;
    logic [1:0]  b_sel, b_oc;
    logic [23:0] b_data;
    logic [2:0]  b_valid, b_rdy;
    logic [7:0]  b_od;

    int errors = 0;
    int checks = 0;

    mux_rr_stream #(.N(4), .W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .mode(a_mode), .sel(a_sel),
        .in_data(a_data), .in_valid(a_valid), .in_ready(a_rdy),
        .out_data(a_od), .out_valid(a_ov), .out_ch(a_oc), .out_ready(a_ordy)
    );

    mux_rr_stream #(.N(3), .W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(b_mode), .sel(b_sel),
        .in_data(b_data), .in_valid(b_valid), .in_ready(b_rdy),
        .out_data(b_od), .out_valid(b_ov), .out_ch(b_oc), .out_ready(b_ordy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Reference model: grant straight from the selection rules.
    function automatic int grant(int n, int md, int s, int v, int p);
        if (md == 0) return (s < n && ((v >> s) & 1) == 1) ? s : -1;
        for (int k = 0; k < n; k++) begin
            int c;
            c = (p + k) % n;
            if (((v >> c) & 1) == 1) return c;
        end
        return -1;
    endfunction

    int m_ptr[2], m_ov[2], m_od[2], m_oc[2];

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = 0; m_ov[d] = 0; m_od[d] = 0; m_oc[d] = 0;
        end
    endfunction

    task automatic rnd_cycle(int cyc);
        int g[2];
        int le[2];
        int n, md, s, v, dat, ordy, rdy, ov, od, oc;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n    = d ? 3 : 4;
            md   = d ? int'(b_mode) : int'(a_mode);
            s    = d ? int'(b_sel) : int'(a_sel);
            v    = d ? int'(b_valid) : int'(a_valid);
            ordy = d ? int'(b_ordy) : int'(a_ordy);
            rdy  = d ? int'(b_rdy) : int'(a_rdy);
            ov   = d ? int'(b_ov) : int'(a_ov);
            od   = d ? int'(b_od) : int'(a_od);
            oc   = d ? int'(b_oc) : int'(a_oc);
            g[d]  = grant(n, md, s, v, m_ptr[d]);
            le[d] = (m_ov[d] == 0 || ordy == 1) ? 1 : 0;
            chk($sformatf("c%0d d%0d in_ready", cyc, d), rdy,
                (rst_n && le[d] == 1 && g[d] >= 0) ? (1 << g[d]) : 0);
            chk($sformatf("c%0d d%0d out_valid", cyc, d), ov, m_ov[d]);
            chk($sformatf("c%0d d%0d out_data", cyc, d), od, m_od[d]);
            chk($sformatf("c%0d d%0d out_ch", cyc, d), oc, m_oc[d]);
        end
        @(posedge clk);
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                n   = d ? 3 : 4;
                md  = d ? int'(b_mode) : int'(a_mode);
                dat = d ? int'(b_data) : int'(a_data);
                if (le[d] == 1) begin
                    if (g[d] >= 0) begin
                        m_ov[d] = 1;
                        m_od[d] = (dat >> (g[d] * 8)) & 8'hFF;
                        m_oc[d] = g[d];
                        if (md == 1) m_ptr[d] = (g[d] + 1) % n;
                    end else begin
                        m_ov[d] = 0;
                    end
                end
            end
        end
        #1;
    endtask

    typedef struct {
        bit         d3;
        bit         md;
        logic [1:0] sel;
        logic [3:0] v;
        bit         ordy;
        logic [3:0] rdy;
        bit         ov;
        logic [7:0] od;
        logic [1:0] oc;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // ch0=C0 ch1=B1 ch2=A5 ch3=D3 ; N=3 instance: ch0=11 ch1=22 ch2=33
        // static / illegal-less select on N=4
        tbl.push_back('{0, 0, 2'd2, 4'hF,    1, 4'b0100, 1, 8'hA5, 2'd2});
        tbl.push_back('{0, 0, 2'd2, 4'b1011, 1, 4'b0000, 0, 8'hA5, 2'd2});
        // round-robin fairness, all valid
        for (int r = 0; r < 2; r++) begin
            tbl.push_back('{0, 1, 2'd0, 4'hF, 1, 4'b0001, 1, 8'hC0, 2'd0});
            tbl.push_back('{0, 1, 2'd0, 4'hF, 1, 4'b0010, 1, 8'hB1, 2'd1});
            tbl.push_back('{0, 1, 2'd0, 4'hF, 1, 4'b0100, 1, 8'hA5, 2'd2});
            tbl.push_back('{0, 1, 2'd0, 4'hF, 1, 4'b1000, 1, 8'hD3, 2'd3});
        end
        // sparse valid 1010
        for (int r = 0; r < 2; r++) begin
            tbl.push_back('{0, 1, 2'd0, 4'b1010, 1, 4'b0010, 1, 8'hB1, 2'd1});
            tbl.push_back('{0, 1, 2'd0, 4'b1010, 1, 4'b1000, 1, 8'hD3, 2'd3});
        end
        // wrap/skip: grant ch2 -> ptr=3, then 0011 grants ch0 then ch1
        tbl.push_back('{0, 1, 2'd0, 4'b0100, 1, 4'b0100, 1, 8'hA5, 2'd2});
        tbl.push_back('{0, 1, 2'd0, 4'b0011, 1, 4'b0001, 1, 8'hC0, 2'd0});
        tbl.push_back('{0, 1, 2'd0, 4'b0011, 1, 4'b0010, 1, 8'hB1, 2'd1});
        // backpressure 3 cycles, then pop+push without a bubble
        for (int r = 0; r < 3; r++)
            tbl.push_back('{0, 1, 2'd0, 4'hF, 0, 4'b0000, 1, 8'hB1, 2'd1});
        tbl.push_back('{0, 1, 2'd0, 4'hF, 1, 4'b0100, 1, 8'hA5, 2'd2});
        tbl.push_back('{0, 1, 2'd0, 4'hF, 1, 4'b1000, 1, 8'hD3, 2'd3});
        // N=3: illegal select, mode switches with retained ptr
        tbl.push_back('{1, 0, 2'd3, 4'h7, 1, 4'b0000, 0, 8'h00, 2'd0});
        tbl.push_back('{1, 0, 2'd1, 4'h7, 1, 4'b0010, 1, 8'h22, 2'd1});
        tbl.push_back('{1, 1, 2'd0, 4'h7, 1, 4'b0001, 1, 8'h11, 2'd0});
        tbl.push_back('{1, 0, 2'd3, 4'h7, 1, 4'b0000, 0, 8'h11, 2'd0});
        tbl.push_back('{1, 0, 2'd2, 4'h7, 1, 4'b0100, 1, 8'h33, 2'd2});
        tbl.push_back('{1, 1, 2'd0, 4'h7, 1, 4'b0010, 1, 8'h22, 2'd1});
        tbl.push_back('{1, 1, 2'd0, 4'h7, 1, 4'b0100, 1, 8'h33, 2'd2});
        tbl.push_back('{1, 1, 2'd0, 4'h7, 1, 4'b0001, 1, 8'h11, 2'd0});

        // Reset with every input valid
        rst_n  = 1'b0;
        a_mode = 1'b0; a_sel = 2'd2; a_valid = 4'hF; a_ordy = 1'b1;
        a_data = 32'hD3A5B1C0;
        b_mode = 1'b1; b_sel = 2'd0; b_valid = 3'h7; b_ordy = 1'b1;
        b_data = 24'h332211;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst a in_ready", int'(a_rdy), 0);
        chk("rst a out_valid", int'(a_ov), 0);
        chk("rst a out_data", int'(a_od), 0);
        chk("rst a out_ch", int'(a_oc), 0);
        chk("rst b in_ready", int'(b_rdy), 0);
        chk("rst b out_valid", int'(b_ov), 0);
        chk("rst b out_data", int'(b_od), 0);
        chk("rst b out_ch", int'(b_oc), 0);
        @(posedge clk); #1;
        rst_n   = 1'b1;
        b_valid = '0;

        foreach (tbl[i]) begin
            if (!tbl[i].d3) begin
                a_mode = tbl[i].md; a_sel = tbl[i].sel;
                a_valid = tbl[i].v; a_ordy = tbl[i].ordy;
                b_valid = '0; b_ordy = 1'b1;
            end else begin
                b_mode = tbl[i].md; b_sel = tbl[i].sel;
                b_valid = tbl[i].v[2:0]; b_ordy = tbl[i].ordy;
                a_valid = '0; a_ordy = 1'b1;
            end
            @(negedge clk);
            chk($sformatf("row%0d in_ready", i),
                tbl[i].d3 ? int'(b_rdy) : int'(a_rdy), int'(tbl[i].rdy));
            @(posedge clk); #1;
            chk($sformatf("row%0d out_valid", i),
                tbl[i].d3 ? int'(b_ov) : int'(a_ov), int'(tbl[i].ov));
            chk($sformatf("row%0d out_data", i),
                tbl[i].d3 ? int'(b_od) : int'(a_od), int'(tbl[i].od));
            chk($sformatf("row%0d out_ch", i),
                tbl[i].d3 ? int'(b_oc) : int'(a_oc), int'(tbl[i].oc));
        end

        // Randomized traffic against the model, with occasional async resets
        rst_n = 1'b0;
        model_reset();
        rnd_cycle(-1);
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 49) == 0 || c == 150) begin
                rst_n = 1'b0;
                model_reset();
            end else begin
                rst_n = 1'b1;
            end
            a_mode  = 1'($urandom_range(0, 1));
            a_sel   = 2'($urandom_range(0, 3));
            a_valid = 4'($urandom);
            a_data  = $urandom;
            a_ordy  = ($urandom_range(0, 3) != 0);
            b_mode  = 1'($urandom_range(0, 1));
            b_sel   = 2'($urandom_range(0, 3));
            b_valid = 3'($urandom);
            b_data  = 24'($urandom);
            b_ordy  = ($urandom_range(0, 3) != 0);
            rnd_cycle(c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
